// File: rtl/r_exec_ctrl.sv
// rtl/r_exec_ctrl.sv - multi-cycle R-type execute/writeback controller (IDLE->ID->EX->WB)
// Optional macro R_EXEC_SHIFT_EN adds SLL/SRL/SRA; otherwise those functs are illegal.
module r_exec_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [31:0]       inst,
    output logic [ADDR_W-1:0] raddra,
    output logic [ADDR_W-1:0] raddrb,
    input  logic [DATA_W-1:0] douta,
    input  logic [DATA_W-1:0] doutb,
    output logic              wea,
    output logic [ADDR_W-1:0] waddra,
    output logic [DATA_W-1:0] dina,
    output logic              zf,
    output logic              of,
    output logic              illegal
);

    typedef enum logic [1:0] {S_IDLE, S_ID, S_EX, S_WB} state_t;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    state_t            state;
    logic [5:0]        op_r;
    logic [5:0]        funct_r;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              legal_r;

    logic              is_legal;
    logic [DATA_W-1:0] alu_res;
    logic              alu_of;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;

`ifdef R_EXEC_SHIFT_EN
    logic [4:0]        shamt_r;
`else
    logic              unused_shamt;
    assign unused_shamt = ^inst[10:6];
`endif

    assign inst_ready = (state == S_IDLE) && !rsta;
    assign sum        = op_a + op_b;
    assign diff       = op_a - op_b;

    always_comb begin
        is_legal = 1'b0;
        if (op_r == 6'd0) begin
            case (funct_r)
                F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT: is_legal = 1'b1;
`ifdef R_EXEC_SHIFT_EN
                6'h00, 6'h02, 6'h03:                            is_legal = 1'b1;
`endif
                default:                                        is_legal = 1'b0;
            endcase
        end
    end

    // Overflow: operands agree in sign (ADD) or differ (SUB) and the result sign flips from a.
    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        case (funct_r)
            F_ADD: begin
                alu_res = sum;
                alu_of  = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1] != op_a[DATA_W-1]);
            end
            F_SUB: begin
                alu_res = diff;
                alu_of  = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (diff[DATA_W-1] != op_a[DATA_W-1]);
            end
            F_AND: alu_res = op_a & op_b;
            F_OR:  alu_res = op_a | op_b;
            F_XOR: alu_res = op_a ^ op_b;
            F_NOR: alu_res = ~(op_a | op_b);
            F_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
`ifdef R_EXEC_SHIFT_EN
            6'h00: alu_res = op_b << shamt_r;
            6'h02: alu_res = op_b >> shamt_r;
            6'h03: alu_res = $unsigned($signed(op_b) >>> shamt_r);
`endif
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state   <= S_IDLE;
            op_r    <= '0;
            funct_r <= '0;
            op_a    <= '0;
            op_b    <= '0;
            legal_r <= 1'b0;
            raddra  <= '0;
            raddrb  <= '0;
            waddra  <= '0;
            dina    <= '0;
            wea     <= 1'b0;
            illegal <= 1'b0;
            zf      <= 1'b0;
            of      <= 1'b0;
`ifdef R_EXEC_SHIFT_EN
            shamt_r <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    wea     <= 1'b0;
                    illegal <= 1'b0;
                    if (inst_valid) begin
                        op_r    <= inst[31:26];
                        raddra  <= inst[25:21];
                        raddrb  <= inst[20:16];
                        waddra  <= inst[15:11];
                        funct_r <= inst[5:0];
`ifdef R_EXEC_SHIFT_EN
                        shamt_r <= inst[10:6];
`endif
                        state   <= S_ID;
                    end
                end
                S_ID: begin
                    op_a    <= douta;
                    op_b    <= doutb;
                    legal_r <= is_legal;
                    state   <= S_EX;
                end
                S_EX: begin
                    // Flags and write data only move for legal instructions.
                    if (legal_r) begin
                        dina <= alu_res;
                        zf   <= (alu_res == '0);
                        of   <= alu_of;
                        wea  <= 1'b1;
                    end else begin
                        illegal <= 1'b1;
                    end
                    state <= S_WB;
                end
                S_WB: begin
                    wea     <= 1'b0;
                    illegal <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_r_exec_ctrl.sv
// tb/tb_r_exec_ctrl.sv - scoreboard bench for r_exec_ctrl with a behavioural register file
module tb_r_exec_ctrl;

    logic        clka = 1'b0;
    logic        rsta = 1'b0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [31:0] inst = '0;
    logic [4:0]  raddra, raddrb, waddra;
    logic [31:0] douta, doutb, dina;
    logic        wea, zf, of, illegal;

    logic [31:0] rf  [32];
    logic [31:0] mrf [32];

    typedef struct {
        int          acc;
        logic [4:0]  rs, rt, rd;
        logic [31:0] data;
        bit          ill, zf, of;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_acc = -1;
    bit got_acc;
    bit b2b_mode = 0;
    bit m_zf = 0, m_of = 0;
    logic [31:0] saved;

    always #5 clka = ~clka;

    assign douta = rf[raddra];
    assign doutb = rf[raddrb];

    r_exec_ctrl #(.DATA_W(32), .ADDR_W(5)) dut (
        .clka(clka), .rsta(rsta), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .raddra(raddra), .raddrb(raddrb), .douta(douta), .doutb(doutb),
        .wea(wea), .waddra(waddra), .dina(dina), .zf(zf), .of(of), .illegal(illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] rinst(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
        return {op, rs, rt, rd, sh, fn};
    endfunction

    function automatic void model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                                  output bit ok, output logic [31:0] r, output bit ofl);
        longint sa, sb_, s;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        ok = 1; ofl = 0; r = '0;
        if (i[31:26] != 6'd0) ok = 0;
        else begin
            case (i[5:0])
                6'h20: begin s = sa + sb_; r = s[31:0]; ofl = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
                6'h22: begin s = sa - sb_; r = s[31:0]; ofl = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h2A: r = (sa < sb_) ? 32'd1 : 32'd0;
`ifdef R_EXEC_SHIFT_EN
                6'h00: r = b << i[10:6];
                6'h02: r = b >> i[10:6];
                6'h03: r = 32'($signed(b) >>> i[10:6]);
`endif
                default: ok = 0;
            endcase
        end
    endfunction

    // One clock: predict on accept, then check ID addresses and any write-back at the negedge.
    task automatic tick();
        bit acc, ok, ofl;
        logic [31:0] r;
        exp_t e;
        acc = inst_valid && inst_ready;
        got_acc = 0;
        if (acc) begin
            model(inst, mrf[inst[25:21]], mrf[inst[20:16]], ok, r, ofl);
            e.acc = cyc; e.rs = inst[25:21]; e.rt = inst[20:16]; e.rd = inst[15:11];
            e.data = r; e.ill = !ok;
            if (ok) begin
                if (inst[15:11] != 5'd0) mrf[inst[15:11]] = r;
                m_zf = (r == 32'd0);
                m_of = ofl;
            end
            e.zf = m_zf; e.of = m_of;
            sb.push_back(e);
            if (b2b_mode && last_acc >= 0) chk("ready_interval", 32'(cyc - last_acc), 32'd4);
            last_acc = cyc;
            got_acc = 1;
        end
        @(posedge clka);
        cyc++;
        @(negedge clka);
        if (acc) begin
            chk("id_raddra", {27'd0, raddra}, {27'd0, sb[$].rs});
            chk("id_raddrb", {27'd0, raddrb}, {27'd0, sb[$].rt});
        end
        if (wea || illegal) begin
            if (sb.size() == 0) begin
                chk("unexpected_wb", {30'd0, wea, illegal}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_latency", 32'(cyc - e.acc), 32'd3);
                chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
                chk("wea", {31'd0, wea}, {31'd0, !e.ill});
                if (!e.ill) begin
                    chk("waddra", {27'd0, waddra}, {27'd0, e.rd});
                    chk("dina", dina, e.data);
                end
                chk("zf", {31'd0, zf}, {31'd0, e.zf});
                chk("of", {31'd0, of}, {31'd0, e.of});
                if (wea && waddra != 5'd0) rf[waddra] = dina;
            end
        end
    endtask

    task automatic send(input logic [31:0] i, input bit hold);
        bit done;
        done = 0;
        inst = i;
        inst_valid = 1;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            done = got_acc;
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        if (!hold) inst_valid = 0;
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && sb.size() > 0; k++) tick();
        chk("drain", 32'(sb.size()), 32'd0);
        repeat (3) tick();
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        rf[idx] = v;
        mrf[idx] = v;
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin
            rf[k] = '0;
            mrf[k] = '0;
        end
        #1 rsta = 1;
        #1;
        chk("rst_wea", {31'd0, wea}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_flags", {30'd0, zf, of}, 32'd0);
        chk("rst_addrs", {17'd0, raddra, raddrb, waddra}, 32'd0);
        chk("rst_dina", dina, 32'd0);
        chk("rst_ready_low", {31'd0, inst_ready}, 32'd0);
        @(negedge clka);
        rsta = 0;
        #1 chk("ready_after_rst", {31'd0, inst_ready}, 32'd1);

        preload(1, 32'd5);
        preload(2, 32'd7);
        send(rinst(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 0);
        drain();
        chk("r3_is_12", rf[3], 32'd12);

        preload(1, 32'h7FFF_FFFF);
        preload(2, 32'd1);
        send(rinst(6'd0, 5'd1, 5'd2, 5'd4, 5'd0, 6'h20), 0);
        send(rinst(6'd0, 5'd1, 5'd1, 5'd5, 5'd0, 6'h22), 0);
        drain();
        chk("r4_is_min", rf[4], 32'h8000_0000);
        chk("zf_after_sub", {31'd0, zf}, 32'd1);

        // Reset while the instruction sits in EX: no write, flags cleared.
        saved = mrf[7];
        send(rinst(6'd0, 5'd1, 5'd2, 5'd7, 5'd0, 6'h20), 0);
        tick();
        #2 rsta = 1;
        #1;
        chk("midrst_wea", {31'd0, wea}, 32'd0);
        chk("midrst_flags", {30'd0, zf, of}, 32'd0);
        chk("midrst_dina", dina, 32'd0);
        chk("midrst_waddra", {27'd0, waddra}, 32'd0);
        chk("midrst_ready", {31'd0, inst_ready}, 32'd0);
        sb.delete();
        mrf[7] = saved;
        m_zf = 0;
        m_of = 0;
        tick();
        tick();
        rsta = 0;
        #1 chk("midrst_ready_after", {31'd0, inst_ready}, 32'd1);
        repeat (4) tick();
        chk("midrst_no_write", rf[7], saved);

        preload(1, 32'hFFFF_FFFF);
        preload(2, 32'd1);
        send(rinst(6'd0, 5'd1, 5'd2, 5'd6, 5'd0, 6'h2A), 0);
        preload(8, 32'hF0F0_F0F0);
        preload(9, 32'h0FF0_0FF0);
        send(rinst(6'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h24), 0);
        send(rinst(6'd0, 5'd8, 5'd9, 5'd11, 5'd0, 6'h25), 0);
        send(rinst(6'd0, 5'd8, 5'd9, 5'd12, 5'd0, 6'h26), 0);
        send(rinst(6'd0, 5'd8, 5'd9, 5'd13, 5'd0, 6'h27), 0);
        drain();
        chk("slt_r6", rf[6], 32'd1);
        chk("and_r10", rf[10], 32'h00F0_00F0);
        chk("or_r11", rf[11], 32'hFFF0_FFF0);
        chk("xor_r12", rf[12], 32'hFF00_FF00);
        chk("nor_r13", rf[13], 32'h000F_000F);

        send(rinst(6'h23, 5'd8, 5'd9, 5'd20, 5'd0, 6'h20), 0);
        send(rinst(6'd0, 5'd8, 5'd9, 5'd21, 5'd0, 6'h18), 0);
        preload(2, 32'd3);
        send(rinst(6'd0, 5'd0, 5'd2, 5'd14, 5'd4, 6'h00), 0);
        preload(22, 32'h8000_0000);
        send(rinst(6'd0, 5'd0, 5'd22, 5'd23, 5'd4, 6'h03), 0);
        drain();
        chk("illegal_no_write_op", rf[20], 32'd0);
        chk("illegal_no_write_fn", rf[21], 32'd0);
`ifdef R_EXEC_SHIFT_EN
        chk("sll_r14", rf[14], 32'd48);
        chk("sra_r23", rf[23], 32'hF800_0000);
`else
        chk("noshift_r14", rf[14], 32'd0);
`endif

        // Back-to-back with inst_valid held; second reads first's rd.
        b2b_mode = 1;
        last_acc = -1;
        send(rinst(6'd0, 5'd1, 5'd2, 5'd15, 5'd0, 6'h20), 1);
        send(rinst(6'd0, 5'd15, 5'd2, 5'd16, 5'd0, 6'h22), 1);
        send(rinst(6'd0, 5'd16, 5'd0, 5'd17, 5'd0, 6'h25), 0);
        b2b_mode = 0;
        drain();
        chk("b2b_r15", rf[15], 32'd2);
        chk("b2b_r16", rf[16], 32'hFFFF_FFFF);
        chk("b2b_r17", rf[17], 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
